// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default widths, register count, x0 index
// and the scan-reader state encoding. Also used by the register file and by
// the hazard/forwarding logic.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** DEF_ADDR_WIDTH;
    localparam int X0_INDEX       = 0;

    typedef enum logic [1:0] {
        SCAN_IDLE   = 2'd0,
        SCAN_RUN    = 2'd1,
        SCAN_FINISH = 2'd2
    } scan_state_e;

endpackage

// File: rtl/regfile_scan_reader_if.sv
// Valid/ready word stream produced by the scan reader.
interface regfile_scan_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_reg;
    logic                  out_last;

    modport master (
        output out_valid, out_data, out_reg, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_reg, out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_scan_outreg.sv
// Single-entry valid/ready output register. load_en captures a new word,
// pop retires the held word, clear drops it (abort) without touching data.
module regfile_scan_outreg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ADDR_WIDTH-1:0] load_reg,
    input  logic                  load_last,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] reg_idx,
    output logic                  last
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] reg_q, reg_d;
    logic                  last_q, last_d;

    // Next-state: clear beats load, load beats pop (refill in the pop cycle)
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        reg_d   = reg_q;
        last_d  = last_q;
        if (clear) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (load_en) begin
            valid_d = 1'b1;
            data_d  = load_data;
            reg_d   = load_reg;
            last_d  = load_last;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    // Output slice registers
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            reg_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            reg_q   <= reg_d;
            last_q  <= last_d;
        end
    end

    assign valid   = valid_q;
    assign data    = data_q;
    assign reg_idx = reg_q;
    assign last    = last_q;

endmodule

// File: rtl/regfile_scan_reader.sv
// Reads a contiguous (wrapping) range of registers through one RF read port
// and streams them out one word per cycle with valid/ready backpressure.
module regfile_scan_reader
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit ZERO_X0    = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_reg,
    input  logic [ADDR_WIDTH-1:0] last_reg,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    regfile_scan_reader_if.master out_if,
    output logic                  busy,
    output logic                  done
);

    scan_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic                  issued_last_q, issued_last_d;

    logic                  load_en;
    logic                  pop;
    logic                  clear;
    logic                  handshake;
    logic                  at_end;
    logic [DATA_WIDTH-1:0] cap_data;

    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic [ADDR_WIDTH-1:0] o_reg;
    logic                  o_last;

    assign handshake = o_valid && out_if.out_ready;
    assign at_end    = (ptr_q == end_q);
    // The register file has no hard-wired x0, so it is masked here
    assign cap_data  = (ZERO_X0 && ptr_q == ADDR_WIDTH'(X0_INDEX)) ? '0 : rd_data;

    // Scan sequencing: start latch, pointer advance, abort and completion
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        end_d         = end_q;
        issued_last_d = issued_last_q;
        load_en       = 1'b0;
        pop           = 1'b0;
        clear         = 1'b0;
        case (state_q)
            SCAN_IDLE: begin
                if (start) begin
                    ptr_d         = first_reg;
                    end_d         = last_reg;
                    issued_last_d = 1'b0;
                    state_d       = SCAN_RUN;
                end
            end
            SCAN_RUN: begin
                if (abort) begin
                    // abort wins over a handshake in the same cycle
                    clear   = 1'b1;
                    state_d = SCAN_IDLE;
                end else begin
                    load_en = !issued_last_q && (!o_valid || out_if.out_ready);
                    pop     = handshake;
                    if (load_en) begin
                        if (at_end) issued_last_d = 1'b1;
                        else        ptr_d = ptr_q + ADDR_WIDTH'(1);
                    end
                    if (handshake && o_last) state_d = SCAN_FINISH;
                end
            end
            SCAN_FINISH: state_d = SCAN_IDLE;
            default:     state_d = SCAN_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= SCAN_IDLE;
            ptr_q         <= '0;
            end_q         <= '0;
            issued_last_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            end_q         <= end_d;
            issued_last_q <= issued_last_d;
        end
    end

    regfile_scan_outreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_outreg (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .pop       (pop),
        .clear     (clear),
        .load_data (cap_data),
        .load_reg  (ptr_q),
        .load_last (at_end),
        .valid     (o_valid),
        .data      (o_data),
        .reg_idx   (o_reg),
        .last      (o_last)
    );

    assign rd_addr          = ptr_q;
    assign out_if.out_valid = o_valid;
    assign out_if.out_data  = o_data;
    assign out_if.out_reg   = o_reg;
    assign out_if.out_last  = o_last;
    assign busy             = (state_q != SCAN_IDLE);
    assign done             = (state_q == SCAN_FINISH);

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Bench for regfile_scan_reader: two instances (x0 masked / not masked) share
// stimulus and a bench-side register file; a range-level model predicts the
// word stream, busy/done and valid timing, checked every falling edge.
module tb_regfile_scan_reader;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] first_reg = '0;
    logic [AW-1:0] last_reg = '0;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] regs [NR];

    bit rdy_rand = 1'b0;
    bit rdy_hold = 1'b0;

    always #5 clock = ~clock;

    // bench register file: write at rising edge, combinational read
    always @(posedge clock) if (we) regs[waddr] <= wdata;

    // ready driver (after stimulus settles in the same cycle)
    always begin
        @(posedge clock);
        #2;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_hold;
    end

    regfile_scan_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    regfile_scan_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    assign bus1.out_ready = out_ready;
    assign bus0.out_ready = out_ready;

    logic [AW-1:0] rd_addr1, rd_addr0;
    logic [DW-1:0] rd_data1, rd_data0;
    logic          busy1, done1, busy0, done0;
    assign rd_data1 = regs[rd_addr1];
    assign rd_data0 = regs[rd_addr0];

    regfile_scan_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_X0(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .first_reg(first_reg),
        .last_reg(last_reg), .abort(abort), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_if(bus1), .busy(busy1), .done(done1));

    regfile_scan_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_X0(1'b0)) dut_nx0 (
        .clock(clock), .reset(reset), .start(start), .first_reg(first_reg),
        .last_reg(last_reg), .abort(abort), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .out_if(bus0), .busy(busy0), .done(done0));

    // index 1 = x0 masked instance, index 0 = unmasked instance
    logic          o_vld  [2];
    logic [DW-1:0] o_dat  [2];
    logic [AW-1:0] o_reg  [2];
    logic          o_last [2];
    logic          o_busy [2];
    logic          o_done [2];
    logic [AW-1:0] o_ra   [2];
    assign o_vld[1] = bus1.out_valid;  assign o_vld[0] = bus0.out_valid;
    assign o_dat[1] = bus1.out_data;   assign o_dat[0] = bus0.out_data;
    assign o_reg[1] = bus1.out_reg;    assign o_reg[0] = bus0.out_reg;
    assign o_last[1] = bus1.out_last;  assign o_last[0] = bus0.out_last;
    assign o_busy[1] = busy1;          assign o_busy[0] = busy0;
    assign o_done[1] = done1;          assign o_done[0] = done0;
    assign o_ra[1] = rd_addr1;         assign o_ra[0] = rd_addr0;

    int total = 0;
    int bad = 0;
    int timeouts = 0;
    int seen_to = 0;

    // literal pins for the model's expected list of the next scan
    int            lit_n = 0;
    int            lit_reg [8];
    logic [DW-1:0] lit_dat [2][8];

    // model state
    bit            act [2];
    bit            fin [2];
    bit            chk_abort [2];
    bit            chk_zero = 1'b0;
    int            age [2];
    int            idx [2];
    int            n_exp [2];
    int            exp_reg [2][NR];
    logic [DW-1:0] exp_dat [2][NR];
    bit            stall [2];
    logic [DW-1:0] prv_dat [2];
    logic [AW-1:0] prv_reg [2];
    logic          prv_last [2];

    task automatic check(input string nm, input int k, input logic [DW-1:0] a, input logic [DW-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, k, $time, a, e);
        end
    endtask

    // compare process: check outputs against the model, then advance the model
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            bit ev;
            ev = act[k] && age[k] >= 1 && idx[k] < n_exp[k];
            check("valid", k, DW'(o_vld[k]), DW'(ev));
            check("busy", k, DW'(o_busy[k]), DW'(act[k] || fin[k]));
            check("done", k, DW'(o_done[k]), DW'(fin[k]));
            if (chk_zero) begin
                check("rst_data", k, o_dat[k], '0);
                check("rst_reg", k, DW'(o_reg[k]), '0);
                check("rst_last", k, DW'(o_last[k]), '0);
                check("rst_rdaddr", k, DW'(o_ra[k]), '0);
            end
            if (chk_abort[k]) check("abort_last", k, DW'(o_last[k]), '0);
            if (ev && o_vld[k]) begin
                check("reg", k, DW'(o_reg[k]), DW'(exp_reg[k][idx[k]]));
                check("data", k, o_dat[k], exp_dat[k][idx[k]]);
                check("last", k, DW'(o_last[k]), DW'(idx[k] == n_exp[k] - 1));
                if (stall[k]) begin
                    check("hold_data", k, o_dat[k], prv_dat[k]);
                    check("hold_reg", k, DW'(o_reg[k]), DW'(prv_reg[k]));
                    check("hold_last", k, DW'(o_last[k]), DW'(prv_last[k]));
                end
            end

            stall[k] = 1'b0;
            chk_abort[k] = 1'b0;
            if (reset) begin
                act[k] = 1'b0;
                fin[k] = 1'b0;
            end else if (act[k] && abort) begin
                act[k] = 1'b0;
                chk_abort[k] = 1'b1;
            end else if (act[k]) begin
                if (ev && out_ready) begin
                    idx[k]++;
                    if (idx[k] == n_exp[k]) begin
                        act[k] = 1'b0;
                        fin[k] = 1'b1;
                    end
                end else if (ev) begin
                    stall[k] = 1'b1;
                    prv_dat[k] = o_dat[k];
                    prv_reg[k] = o_reg[k];
                    prv_last[k] = o_last[k];
                end
                age[k]++;
            end else if (fin[k]) begin
                fin[k] = 1'b0;
            end else if (start) begin
                n_exp[k] = ((int'(last_reg) - int'(first_reg) + NR) % NR) + 1;
                for (int i = 0; i < n_exp[k]; i++) begin
                    exp_reg[k][i] = (int'(first_reg) + i) % NR;
                    exp_dat[k][i] = (k == 1 && exp_reg[k][i] == 0) ? '0 : regs[exp_reg[k][i]];
                end
                act[k] = 1'b1;
                age[k] = 0;
                idx[k] = 0;
                if (lit_n > 0) begin
                    check("lit_count", k, DW'(n_exp[k]), DW'(lit_n));
                    for (int i = 0; i < lit_n; i++) begin
                        check("lit_reg", k, DW'(exp_reg[k][i]), DW'(lit_reg[i]));
                        check("lit_data", k, exp_dat[k][i], lit_dat[k][i]);
                    end
                end
            end
        end
        chk_zero = reset;
        if (timeouts != seen_to) begin
            check("done_timeout", 0, DW'(timeouts), DW'(seen_to));
            seen_to = timeouts;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        we = 1'b1; waddr = AW'(a); wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic go(input int f, input int l);
        first_reg = AW'(f); last_reg = AW'(l); start = 1'b1;
        tick();
        start = 1'b0;
        lit_n = 0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done1) break;
            tick();
        end
        if (i == budget) timeouts++;
        tick();
        tick();
    endtask

    task automatic pin(input int p, input int r, input logic [DW-1:0] d1, input logic [DW-1:0] d0);
        lit_reg[p] = r;
        lit_dat[1][p] = d1;
        lit_dat[0][p] = d0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) wr(i, 32'h0100_0000 | DW'(i));

        // 1: three-word ascending scan
        wr(5, 32'hDEADBEEF); wr(6, 32'h12345678); wr(7, 32'h0);
        rdy_hold = 1'b1;
        tick();
        pin(0, 5, 32'hDEADBEEF, 32'hDEADBEEF);
        pin(1, 6, 32'h12345678, 32'h12345678);
        pin(2, 7, 32'h0, 32'h0);
        lit_n = 3;
        go(5, 7);
        wait_done(20);

        // 2: single word on x0, masked vs unmasked
        wr(0, 32'hFFFFFFFF);
        pin(0, 0, 32'h0, 32'hFFFFFFFF);
        lit_n = 1;
        go(0, 0);
        wait_done(20);

        // 3: wrapping range; a start while busy is ignored
        pin(0, 30, 32'h0100001E, 32'h0100001E);
        pin(1, 31, 32'h0100001F, 32'h0100001F);
        pin(2, 0, 32'h0, 32'hFFFFFFFF);
        pin(3, 1, 32'h01000001, 32'h01000001);
        lit_n = 4;
        go(30, 1);
        first_reg = AW'(9); last_reg = AW'(12); start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20);

        // 4: full 32-word scan under random backpressure
        rdy_rand = 1'b1;
        go(0, 31);
        wait_done(600);
        rdy_rand = 1'b0;
        rdy_hold = 1'b1;
        tick();

        // 5: write to R3 in its capture cycle, then rescan
        wr(3, 32'h11111111);
        pin(0, 3, 32'h11111111, 32'h11111111);
        pin(1, 4, 32'h01000004, 32'h01000004);
        lit_n = 2;
        first_reg = AW'(3); last_reg = AW'(4); start = 1'b1;
        tick();
        start = 1'b0; lit_n = 0;
        we = 1'b1; waddr = AW'(3); wdata = 32'hA5A5A5A5;
        tick();
        we = 1'b0;
        wait_done(20);
        pin(0, 3, 32'hA5A5A5A5, 32'hA5A5A5A5);
        lit_n = 1;
        go(3, 3);
        wait_done(20);

        // 6a: abort after the second word of a ten-word scan, then restart
        abort = 1'b1; tick(); abort = 1'b0;
        go(10, 19);
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(); tick();
        go(20, 21);
        wait_done(20);

        // 6b: reset mid-scan, then a fresh scan
        go(8, 20);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        go(1, 2);
        wait_done(20);

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scan_reader.md
Name: regfile_scan_reader

Overview:
Bus-initiator that reads a contiguous range of architectural registers through one register-file read port and streams them out over a valid/ready interface. It is used for debug dumps, context save and testbench state checks. It sits beside the register file and drives one RR address port in place of the decode stage, which is muxed out by busy. It never writes the register file.

Parameters:
DATA_WIDTH, 32, width of a register and of out_data
ADDR_WIDTH, 5, register index width (NUM_REGS = 2**ADDR_WIDTH)
ZERO_X0, 1, when 1 the value reported for register 0 is forced to 0, because the register file has no hard-wired x0

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
first_reg  in  ADDR_WIDTH  first register index; sampled with start
last_reg  in  ADDR_WIDTH  last register index, inclusive; sampled with start
abort  in  1  cancel an in-progress scan
rd_addr  out  ADDR_WIDTH  drives the register-file read address (RR)
rd_data  in  DATA_WIDTH  combinational register-file read data (RD) for rd_addr
out_valid  out  1  out_data, out_reg and out_last are valid
out_ready  in  1  downstream accepts the word
out_data  out  DATA_WIDTH  captured register value
out_reg  out  ADDR_WIDTH  index of out_data
out_last  out  1  marks the final word of the scan
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle pulse after the last word handshakes

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-high, named reset.
- Reset values: state=IDLE; rd_addr=0, out_valid=0, out_data=0, out_reg=0, out_last=0, busy=0, done=0; ptr=0, end_reg=0, issued_last=0.
- State machine: IDLE, RUN, FINISH.
- IDLE:
  - start=1 latches ptr<=first_reg and end_reg<=last_reg, clears issued_last, and moves to RUN.
  - busy rises the next cycle.
- RUN:
  - rd_addr = ptr (combinational from the register).
  - load_en = !issued_last && (!out_valid || out_ready).
  - On load_en:
    - out_data <= (ZERO_X0 && ptr==0) ? 0 : rd_data
    - out_reg <= ptr, out_valid <= 1, out_last <= (ptr==end_reg)
    - if ptr==end_reg: issued_last <= 1; else ptr <= ptr+1, modulo NUM_REGS.
  - If out_valid && out_ready && !load_en, then out_valid <= 0.
  - When an out_last word handshakes, go to FINISH.
- FINISH: done=1 for exactly one cycle, out_valid=0, busy=0 from the next cycle; return to IDLE.
- Throughput and latency:
  - One word per cycle while out_ready is held high.
  - First out_valid appears 2 cycles after the start cycle: cycle 1 enters RUN, cycle 2 shows the registered output.
- Range:
  - first_reg <= last_reg gives ascending order.
  - first_reg > last_reg wraps 31 -> 0, e.g. 30,31,0,1.
  - first_reg == last_reg emits one word with out_last=1.
  - The maximum scan is 32 words (first = last+1 mod 32).
- Backpressure: while out_valid && !out_ready, out_data, out_reg and out_last hold stable, and ptr does not advance.
- Coherence:
  - Data reflects the register value combinationally visible in the capture cycle.
  - A write to the same register in the capture cycle is not seen, because the register file writes at the rising edge; the next register read sees it.
  - The scan is not atomic across words.
- start while busy is ignored.
- abort in RUN:
  - Next cycle out_valid=0 and out_last=0, state returns to IDLE, and busy=0.
  - No done pulse.
  - abort has priority over a simultaneous handshake.
- abort in IDLE or FINISH: no effect.
- reset mid-scan: every output returns to its reset value the next cycle, and no done pulse is produced.

Decomposition:
- Shared package regfile_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults
  - NUM_REGS
  - the scan state enum (IDLE, RUN, FINISH)
  - the X0_INDEX constant
  - the package is reusable by the register file and by the hazard/forwarding logic
- One natural sub-module, regfile_scan_outreg: a single-entry valid/ready output register slice with load_en, pop and clear.

Test Plan:
1. Preload R5=0xDEADBEEF, R6=0x12345678, R7=0x0; start first=5, last=7, out_ready=1 -> words (5,0xDEADBEEF), (6,0x12345678), (7,0x0) on consecutive cycles, out_last only on R7, done one cycle later, busy then low.
2. Preload R0=0xFFFFFFFF; ZERO_X0=1, scan first=0, last=0 -> single word (0,0x00000000) with out_last=1. With ZERO_X0=0 -> 0xFFFFFFFF.
3. Wrap: scan first=30, last=1 -> out_reg sequence 30,31,0,1, with out_last on 1.
4. Backpressure: full scan 0..31 with out_ready toggling pseudo-randomly -> exactly 32 words, in order, no duplicates, and outputs stable while stalled.
5. Concurrent write: write R3<=0xA5A5A5A5 in the cycle R3 is captured -> the stream shows the old R3 value. A second scan shows 0xA5A5A5A5.
6. Abort and reset:
   - abort after the 2nd word of a 10-word scan -> out_valid=0 next cycle, no done, busy=0; a new start then works.
   - reset mid-scan -> all outputs 0 next cycle.
